// File: rtl/csd_scan_ctrl.sv
// csd_scan_ctrl: scan sequencer for the CSD datapath.
// Walks all 16 memory entries on a go pulse and counts entries that read 8'h01.
// While idle, host read/write requests pass straight through to the memory port.
// Ports:
//   clk, reset (async active-low)            clock and reset
//   go, abort                                start a scan / cancel a running scan
//   host_we, host_re                         host memory requests, honoured in IDLE only
//   Zi, Zcsd                                 datapath flags (index < 15, dataOut == 8'h01)
//   start, weCsd, reCsd                      address select and memory enables
//   Load, enable                             index counter clear / increment
//   loadCnt, enCnt                           match counter clear / increment
//   busy, done                               scan in progress / one-cycle completion pulse
module csd_scan_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic abort,
  input  logic host_we,
  input  logic host_re,
  input  logic Zi,
  input  logic Zcsd,
  output logic start,
  output logic weCsd,
  output logic reCsd,
  output logic Load,
  output logic enable,
  output logic loadCnt,
  output logic enCnt,
  output logic busy,
  output logic done
);
  typedef enum logic [2:0] {IDLE, INIT, RD, WAIT, EVAL, DONE} state_t;
  state_t state, next;
  logic [2:0] wcnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= next;
      wcnt  <= state == RD ? 3'd0 : state == WAIT ? wcnt + 3'd1 : wcnt;
    end
  // The IDLE pass-through is gated by reset so every output is 0 while reset is held.
  always_comb begin
    next    = state;
    start   = 1'b0;
    weCsd   = 1'b0;
    reCsd   = 1'b0;
    Load    = 1'b0;
    enable  = 1'b0;
    loadCnt = 1'b0;
    enCnt   = 1'b0;
    busy    = state != IDLE;
    done    = 1'b0;
    case (state)
      IDLE: begin
        weCsd = reset & host_we;
        reCsd = reset & host_re;
        next  = go ? INIT : IDLE;
      end
      INIT: begin
        start   = 1'b1;
        Load    = 1'b1;
        loadCnt = 1'b1;
        next    = RD;
      end
      RD: begin
        start = 1'b1;
        reCsd = 1'b1;
        next  = WAIT;
      end
      WAIT: begin
        start = 1'b1;
        reCsd = 1'b1;
        next  = wcnt == 3'(RD_LAT - 1) ? EVAL : WAIT;
      end
      EVAL: begin
        start  = 1'b1;
        enCnt  = Zcsd;
        enable = Zi;
        next   = Zi ? RD : DONE;
      end
      DONE: begin
        start = 1'b1;
        done  = 1'b1;
        next  = IDLE;
      end
      default: next = IDLE;
    endcase
    if (abort && state != IDLE) next = IDLE;
  end
endmodule

// File: tb/tb_csd_scan_ctrl.sv
// tb_csd_scan_ctrl: directed bench for csd_scan_ctrl with a behavioural datapath per instance.
module tb_csd_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;

  logic go_a = 1'b0, hwe_a = 1'b0, hre_a = 1'b0;
  logic [3:0] haddr_a = '0;
  logic [7:0] hdata_a = '0;
  logic start_a, we_a, re_a, ld_a, en_a, ldc_a, enc_a, busy_a, done_a;
  logic [7:0] mem_a [16];
  logic [7:0] dout_a;
  logic [3:0] idx_a, cnt_a;
  wire [3:0] addr_a = start_a ? idx_a : haddr_a;
  wire zi_a = idx_a < 4'hF;
  wire zcsd_a = dout_a == 8'h01;
  wire [8:0] outs_a = {start_a, we_a, re_a, ld_a, en_a, ldc_a, enc_a, busy_a, done_a};

  csd_scan_ctrl #(.RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .abort(abort), .host_we(hwe_a), .host_re(hre_a),
    .Zi(zi_a), .Zcsd(zcsd_a), .start(start_a), .weCsd(we_a), .reCsd(re_a), .Load(ld_a),
    .enable(en_a), .loadCnt(ldc_a), .enCnt(enc_a), .busy(busy_a), .done(done_a)
  );

  always @(posedge clk or negedge reset)
    if (!reset) begin
      idx_a <= '0;
      cnt_a <= '0;
      dout_a <= '0;
    end else begin
      if (we_a) mem_a[addr_a] <= hdata_a;
      if (re_a) dout_a <= mem_a[addr_a];
      if (ld_a) idx_a <= '0; else if (en_a) idx_a <= idx_a + 4'd1;
      if (ldc_a) cnt_a <= '0; else if (enc_a) cnt_a <= cnt_a + 4'd1;
    end

  logic go_b = 1'b0, hwe_b = 1'b0;
  logic [3:0] haddr_b = '0;
  logic [7:0] hdata_b = '0;
  logic start_b, we_b, re_b, ld_b, en_b, ldc_b, enc_b, busy_b, done_b;
  logic [7:0] mem_b [16];
  logic [7:0] pipe_b [3];
  logic [3:0] idx_b, cnt_b;
  wire [3:0] addr_b = start_b ? idx_b : haddr_b;
  wire zi_b = idx_b < 4'hF;
  wire zcsd_b = pipe_b[2] == 8'h01;

  csd_scan_ctrl #(.RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .abort(abort), .host_we(hwe_b), .host_re(1'b0),
    .Zi(zi_b), .Zcsd(zcsd_b), .start(start_b), .weCsd(we_b), .reCsd(re_b), .Load(ld_b),
    .enable(en_b), .loadCnt(ldc_b), .enCnt(enc_b), .busy(busy_b), .done(done_b)
  );

  always @(posedge clk or negedge reset)
    if (!reset) begin
      idx_b <= '0;
      cnt_b <= '0;
    end else begin
      if (we_b) mem_b[addr_b] <= hdata_b;
      if (re_b) pipe_b[0] <= mem_b[addr_b];
      for (int k = 1; k < 3; k++) pipe_b[k] <= pipe_b[k-1];
      if (ld_b) idx_b <= '0; else if (en_b) idx_b <= idx_b + 4'd1;
      if (ldc_b) cnt_b <= '0; else if (enc_b) cnt_b <= cnt_b + 4'd1;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input logic [15:0] ones);
    for (int i = 0; i < 16; i++) begin
      haddr_a = 4'(i);
      hdata_a = ones[i] ? 8'h01 : 8'h00;
      hwe_a = 1'b1;
      tick();
    end
    hwe_a = 1'b0;
  endtask

  task automatic fill_b(input logic [15:0] ones);
    for (int i = 0; i < 16; i++) begin
      haddr_b = 4'(i);
      hdata_b = ones[i] ? 8'h01 : 8'h00;
      hwe_b = 1'b1;
      tick();
    end
    hwe_b = 1'b0;
  endtask

  // Pulses go, then runs len edges; go is re-raised before edges g2/g3 when nonzero.
  task automatic scan_a(input int len, input int g2, input int g3,
                        output int first, output int pulses, output logic [3:0] idx1, output logic [3:0] cnt1);
    first = 0;
    pulses = 0;
    idx1 = 'x;
    cnt1 = 'x;
    go_a = 1'b1;
    tick();
    for (int n = 1; n <= len; n++) begin
      go_a = (n == g2 || n == g3);
      tick();
      if (n == 1) begin
        idx1 = idx_a;
        cnt1 = cnt_a;
      end
      if (done_a) begin
        if (first == 0) first = n;
        pulses++;
      end
    end
    go_a = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    hwe_a = 1'b1;
    hre_a = 1'b1;
    tick();
    n_checks++;
    if (outs_a !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", outs_a, 9'b0);
    end
    hwe_a = 1'b0;
    hre_a = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy_a);
    end
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({start_a, re_a, busy_a} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_wait_state: start/re/busy got %b expected 111", {start_a, re_a, busy_a});
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (outs_a !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", outs_a, 9'b0);
    end
    tick();
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy_a) n++;
    end
    n_checks++;
    if (n !== 0) begin
      n_fail++;
      $display("FAIL reset_release_busy: busy cycles got %0d expected 0", n);
    end
  endtask

  task automatic test_scan;
    int first, pulses;
    logic [3:0] i1, c1;
    fill_a(16'h0208);
    scan_a(60, 0, 0, first, pulses, i1, c1);
    n_checks++;
    if (first !== 49) begin
      n_fail++;
      $display("FAIL scan_done_edge: got %0d expected 49", first);
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL scan_done_pulses: got %0d expected 1", pulses);
    end
    n_checks++;
    if (cnt_a !== 4'd2) begin
      n_fail++;
      $display("FAIL scan_match_count: got %0d expected 2", cnt_a);
    end
    n_checks++;
    if (idx_a !== 4'd15) begin
      n_fail++;
      $display("FAIL scan_index: got %0d expected 15", idx_a);
    end
  endtask

  task automatic test_host;
    int n;
    haddr_a = 4'h5;
    hdata_a = 8'h01;
    hwe_a = 1'b1;
    #1;
    n_checks++;
    if ({we_a, start_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL host_we_idle: we/start got %b expected 10", {we_a, start_a});
    end
    hwe_a = 1'b0;
    hre_a = 1'b1;
    #1;
    n_checks++;
    if ({re_a, we_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL host_re_idle: re/we got %b expected 10", {re_a, we_a});
    end
    hre_a = 1'b0;
    hwe_a = 1'b1;
    tick();
    hwe_a = 1'b0;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    tick();
    tick();
    haddr_a = 4'h7;
    hwe_a = 1'b1;
    #1;
    n_checks++;
    if (we_a !== 1'b0) begin
      n_fail++;
      $display("FAIL host_we_busy: got %b expected 0", we_a);
    end
    hwe_a = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL host_scan_timeout: busy got %b expected 0", busy_a);
    end
    n_checks++;
    if (cnt_a !== 4'd3) begin
      n_fail++;
      $display("FAIL host_write_landed: match count got %0d expected 3", cnt_a);
    end
  endtask

  task automatic test_abort;
    int evals, dones, first, pulses;
    logic [3:0] i1, c1;
    evals = 0;
    dones = 0;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    for (int n = 0; n < 100 && evals < 5; n++) begin
      tick();
      if (done_a) dones++;
      if (en_a) evals++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy got %b expected 0", busy_a);
    end
    n_checks++;
    if ({idx_a, cnt_a} !== {4'd5, 4'd1}) begin
      n_fail++;
      $display("FAIL abort_counters: idx/cnt got %0d/%0d expected 5/1", idx_a, cnt_a);
    end
    for (int n = 0; n < 60; n++) begin
      if (done_a) dones++;
      tick();
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: done pulses got %0d expected 0", dones);
    end
    scan_a(60, 0, 0, first, pulses, i1, c1);
    n_checks++;
    if ({i1, c1} !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_restart: idx/cnt after INIT got %0d/%0d expected 0/0", i1, c1);
    end
    n_checks++;
    if (first !== 49 || cnt_a !== 4'd3) begin
      n_fail++;
      $display("FAIL abort_rescan: done edge/count got %0d/%0d expected 49/3", first, cnt_a);
    end
  endtask

  task automatic test_rd_lat3;
    int first, pulses, n;
    fill_b(16'hFFFF);
    first = 0;
    pulses = 0;
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (done_b) begin
        if (first == 0) first = n;
        pulses++;
      end
    end
    n_checks++;
    if (first !== 81 || pulses !== 1) begin
      n_fail++;
      $display("FAIL lat3_done: edge/pulses got %0d/%0d expected 81/1", first, pulses);
    end
    n_checks++;
    if ({idx_b, cnt_b} !== {4'd15, 4'd0}) begin
      n_fail++;
      $display("FAIL lat3_counters: idx/cnt got %0d/%0d expected 15/0", idx_b, cnt_b);
    end
  endtask

  task automatic test_back_to_back;
    int first, pulses;
    logic [3:0] i1, c1;
    scan_a(70, 10, 50, first, pulses, i1, c1);
    n_checks++;
    if (first !== 49 || pulses !== 1) begin
      n_fail++;
      $display("FAIL go_while_busy: edge/pulses got %0d/%0d expected 49/1", first, pulses);
    end
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL go_at_done: busy got %b expected 0", busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_host();
    test_abort();
    test_rd_lat3();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
